instr_fetch: RTL and testbench

- Fetch sequencer between the program-counter register and instruction memory.
- Drives the PC register's next-value input every cycle; the PC register loads unconditionally on each clock edge, so this block holds the PC by feeding back the current value.
- Issues one read per PC over a req/ack handshake and presents the fetched word downstream with a valid/ready handshake.
- Applies branch redirects, including redirects that arrive while a read is outstanding.

---
 rtl/instr_fetch_pkg.sv | 18 +
 rtl/instr_fetch.sv | 97 +++++++++
 tb/tb_instr_fetch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// instruction size and PC alignment helper.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch sequencer: steers the PC register, issues one memory read per PC and
// hands fetched words downstream, applying branch redirects at any point.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        addr_err
);

  fetch_state_t state;
  logic         pend;
  logic [31:0]  pend_target;
  logic [31:0]  br_target;
  logic [31:0]  redirect_target;
  logic         redirect;

  assign br_target       = align_pc(branch_target);
  // A branch in the same cycle as the ack is newer than any pending one.
  assign redirect_target = branch_taken ? br_target : pend_target;
  assign redirect        = pend || branch_taken;

  assign mem_req     = (state == ST_REQ);
  assign instr_valid = (state == ST_VALID);
  assign mem_addr    = pc_in;

  always_comb begin
    next_pc = pc_in;
    if (rst) begin
      next_pc = RESET_PC;
    end else begin
      case (state)
        ST_REQ: begin
          if (mem_ack) next_pc = redirect ? redirect_target : pc_in + INSTR_BYTES;
        end
        ST_VALID: begin
          if (branch_taken) next_pc = br_target;
        end
        default: next_pc = pc_in;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pend     <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= branch_taken && (branch_target[1:0] != 2'b00);
      case (state)
        ST_IDLE: begin
          state <= ST_REQ;
          if (branch_taken) begin
            pend        <= 1'b1;
            pend_target <= br_target;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            // Redirected reads are dropped; the new request issues from REQ.
            pend <= 1'b0;
            if (!redirect) begin
              instr    <= mem_rdata;
              instr_pc <= pc_in;
              state    <= ST_VALID;
            end
          end else if (branch_taken) begin
            pend        <= 1'b1;
            pend_target <= br_target;
          end
        end
        ST_VALID: begin
          if (branch_taken || instr_ready) state <= ST_REQ;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: transaction-level model of the fetch stream with a
// scoreboard of expected deliveries, directed scenarios and random traffic.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [31:0] next_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        addr_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } item_t;

  item_t sb[$];
  int    vectors    = 0;
  int    miscompares = 0;

  // Model of the fetch stream
  bit          m_idle;
  bit          m_out;
  bit          m_pend;
  logic [31:0] m_pend_tgt;
  logic [31:0] m_addr;
  bit          m_err;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_in        (pc_in),
    .next_pc      (next_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  // PC register: loads unconditionally every edge
  always @(posedge clk) pc_in <= next_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; holds rst for n edges, optionally acking throughout.
  task automatic do_reset(input int n, input bit ack_during);
    rst          = 1'b1;
    mem_ack      = ack_during;
    mem_rdata    = 32'hBAD0_BAD0;
    instr_ready  = 1'b1;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_instr_valid", instr_valid, 1'b0);
      chk1("rst_addr_err", addr_err, 1'b0);
      chk("rst_pc", pc_in, RST_PC);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
    end
    rst     = 1'b0;
    mem_ack = 1'b0;
    sb.delete();
    m_idle = 1'b1;
    m_out  = 1'b0;
    m_pend = 1'b0;
    m_addr = RST_PC;
    m_err  = 1'b0;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance model.
  task automatic cycle(input bit a, input logic [31:0] d, input bit rdy,
                       input bit br, input logic [31:0] tgt);
    bit          req_exp;
    bit          ack;
    logic [31:0] t;
    req_exp = !m_idle && !m_out;
    chk1("mem_req", mem_req, req_exp);
    chk1("instr_valid", instr_valid, m_out);
    chk1("addr_err", addr_err, m_err);
    chk("pc_in", pc_in, m_addr);
    if (req_exp) chk("mem_addr", mem_addr, m_addr);

    ack           = a && req_exp;
    mem_ack       = ack;
    mem_rdata     = d;
    instr_ready   = rdy;
    branch_taken  = br;
    branch_target = tgt;

    m_err = br && (tgt[1:0] != 2'b00);
    t     = {tgt[31:2], 2'b00};
    if (m_idle) begin
      m_idle = 1'b0;
      if (br) begin m_pend = 1'b1; m_pend_tgt = t; end
    end else if (m_out) begin
      if (br) begin m_out = 1'b0; m_addr = t; end
      else if (rdy) m_out = 1'b0;
    end else if (ack) begin
      if (br) begin m_addr = t; m_pend = 1'b0; end
      else if (m_pend) begin m_addr = m_pend_tgt; m_pend = 1'b0; end
      else begin
        sb.push_back('{pc: m_addr, data: d});
        m_addr = m_addr + 32'd4;
        m_out  = 1'b1;
      end
    end else if (br) begin
      m_pend = 1'b1; m_pend_tgt = t;
    end
    @(negedge clk);
  endtask

  // Monitor: every delivery or flush of a presented instruction pops the scoreboard.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && instr_valid && (instr_ready || branch_taken)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: instr_pc %h instr %h presented, none expected", instr_pc, instr);
        end else begin
          e = sb.pop_front();
          chk("instr", instr, e.data);
          chk("instr_pc", instr_pc, e.pc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    branch_taken = 1'b0; branch_target = '0;

    // Reset, wait states, backpressure
    do_reset(2, 1'b1);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'hDEAD_BEEF, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // Redirect while a read is outstanding
    cycle(0, 0, 0, 1, 32'h0000_0200);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h1111_1111, 0, 0, 0);
    cycle(1, 32'h2222_2222, 0, 0, 0);

    // Branch in VALID together with ready
    cycle(0, 0, 1, 1, 32'h0000_0300);
    cycle(1, 32'h3333_3333, 0, 0, 0);

    // PC wrap at the top of the address space
    cycle(0, 0, 1, 1, 32'hFFFF_FFFC);
    cycle(1, 32'h4444_4444, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // Misaligned target with ack in the same cycle
    cycle(1, 32'h5555_5555, 0, 1, 32'h0000_0203);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h6666_6666, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // Reset mid-request with ack during rst, then branch in IDLE
    do_reset(1, 1'b1);
    cycle(0, 0, 0, 1, 32'h0000_0400);
    cycle(1, 32'h7777_7777, 0, 0, 0);
    cycle(1, 32'h8888_8888, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1 + int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        cycle(($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), $urandom);
      end
    end

    // Drain
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    @(negedge clk);
    chk("sb_left", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "timeout");
  end

endmodule
